// File: rtl/gaussian_blur_stream_if.sv
// gaussian_blur_stream_if: row-wide SRAM buses of the blur engine.
// Ports (master = engine side):
//   src_rd, src_addr   -> image SRAM row read request
//   src_data           <- image row, valid one cycle after src_rd
//   dst_we, dst_addr   -> blur SRAM row write strobe and row index
//   dst_data           -> blurred row
//   dst_stall          <- sink not ready, holds the pending write
interface gaussian_blur_stream_if #(
   parameter int PIX_W  = 8,
   parameter int IMG_W  = 640,
   parameter int ADDR_W = 9
);
   logic                     src_rd;
   logic [ADDR_W-1:0]        src_addr;
   logic [IMG_W*PIX_W-1:0]   src_data;
   logic                     dst_we;
   logic [ADDR_W-1:0]        dst_addr;
   logic [IMG_W*PIX_W-1:0]   dst_data;
   logic                     dst_stall;
   modport master(output src_rd, src_addr, dst_we, dst_addr, dst_data, input src_data, dst_stall);
   modport slave(input src_rd, src_addr, dst_we, dst_addr, dst_data, output src_data, dst_stall);
endinterface

// File: rtl/gaussian_blur_stream.sv
// gaussian_blur_stream: row-streaming 3x3/5x5 binomial blur with a 5-row window and zero padding.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   start, mode frame request (IDLE only); mode 0 = 3x3, 1 = 5x5, sampled on start
//   busy, done  frame in progress level, one-cycle completion pulse
//   bus         master side of gaussian_blur_stream_if (image read, blur write, stall)
module gaussian_blur_stream #(
   parameter int PIX_W  = 8,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 481,
   parameter int ADDR_W = 9
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   mode,
   output logic                   busy,
   output logic                   done,
   gaussian_blur_stream_if.master bus
);
   localparam int RW = IMG_W*PIX_W;
   localparam int AW = PIX_W+8;
   localparam int SW = ADDR_W+1;
   typedef enum logic [2:0] {IDLE, READ, LOAD, CALC, WRITE, DONE} state_t;
   state_t            state_q, state_d;
   logic [SW-1:0]     s_q, s_d, r;
   logic              mode_q, mode_d, busy_q, src_rd_q, src_rd_d;
   logic [ADDR_W-1:0] src_addr_q, src_addr_d, dst_addr_q, dst_addr_d;
   logic [RW-1:0]     dst_data_q, dst_data_d, blur_row;
   logic [RW-1:0]     win_q [5];
   logic [RW-1:0]     win_d [5];
   logic [AW-1:0]     vp [IMG_W+4];
   assign r = mode_q ? SW'(2) : SW'(1);
   // Vertical pass, padded by two zero columns on each side so the horizontal pass needs no bounds logic.
   for (genvar c = 0; c < IMG_W+4; c++) begin : g_vert
      if (c < 2 || c > IMG_W+1) begin : g_pad
         assign vp[c] = '0;
      end else begin : g_pix
         logic [AW-1:0] p0, p1, p2, p3, p4;
         assign p0 = AW'(win_q[0][(c-2)*PIX_W +: PIX_W]);
         assign p1 = AW'(win_q[1][(c-2)*PIX_W +: PIX_W]);
         assign p2 = AW'(win_q[2][(c-2)*PIX_W +: PIX_W]);
         assign p3 = AW'(win_q[3][(c-2)*PIX_W +: PIX_W]);
         assign p4 = AW'(win_q[4][(c-2)*PIX_W +: PIX_W]);
         assign vp[c] = mode_q ? AW'(p0 + 4*p1 + 6*p2 + 4*p3 + p4) : AW'(p0 + 2*p1 + p2);
      end
   end
   for (genvar c = 0; c < IMG_W; c++) begin : g_horz
      logic [AW-1:0] acc;
      assign acc = mode_q ? AW'(vp[c] + 4*vp[c+1] + 6*vp[c+2] + 4*vp[c+3] + vp[c+4])
                          : AW'(vp[c+1] + 2*vp[c+2] + vp[c+3]);
      assign blur_row[c*PIX_W +: PIX_W] = mode_q ? PIX_W'((acc + AW'(128)) >> 8) : PIX_W'((acc + AW'(8)) >> 4);
   end
   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      mode_d     = mode_q;
      win_d      = win_q;
      dst_addr_d = dst_addr_q;
      dst_data_d = dst_data_q;
      case (state_q)
         IDLE: if (start) begin
            state_d = READ;
            s_d     = '0;
            mode_d  = mode;
            win_d   = '{default: '0};
         end
         READ: state_d = LOAD;
         LOAD: begin
            state_d  = CALC;
            win_d[4] = win_q[3];
            win_d[3] = win_q[2];
            win_d[2] = win_q[1];
            win_d[1] = win_q[0];
            win_d[0] = s_q < SW'(IMG_H) ? bus.src_data : '0;
         end
         CALC: begin
            state_d    = WRITE;
            dst_data_d = blur_row;
            dst_addr_d = ADDR_W'(s_q - r);
         end
         WRITE: if (s_q < r || !bus.dst_stall) begin
            state_d = s_q == SW'(IMG_H-1) + r ? DONE : READ;
            s_d     = s_q == SW'(IMG_H-1) + r ? s_q : s_q + SW'(1);
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
      src_rd_d   = state_d == READ && s_d < SW'(IMG_H);
      src_addr_d = src_rd_d ? ADDR_W'(s_d) : src_addr_q;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q    <= IDLE;
         s_q        <= '0;
         mode_q     <= 1'b0;
         busy_q     <= 1'b0;
         src_rd_q   <= 1'b0;
         src_addr_q <= '0;
         dst_addr_q <= '0;
         dst_data_q <= '0;
         win_q      <= '{default: '0};
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         mode_q     <= mode_d;
         busy_q     <= state_d != IDLE;
         src_rd_q   <= src_rd_d;
         src_addr_q <= src_addr_d;
         dst_addr_q <= dst_addr_d;
         dst_data_q <= dst_data_d;
         win_q      <= win_d;
      end
   assign busy         = busy_q;
   assign done         = state_q == DONE;
   assign bus.src_rd   = src_rd_q;
   assign bus.src_addr = src_addr_q;
   assign bus.dst_addr = dst_addr_q;
   assign bus.dst_data = dst_data_q;
   assign bus.dst_we   = state_q == WRITE && s_q >= r && !bus.dst_stall;
endmodule

// File: tb/tb_gaussian_blur_stream.sv
// tb_gaussian_blur_stream: scoreboard bench for gaussian_blur_stream on an 8x6 image.
module tb_gaussian_blur_stream;
   localparam int PW = 8, W = 8, H = 6, AW = 3;
   logic clk = 0, rst = 1, start = 0, mode = 0;
   logic busy, done;
   always #5 clk = ~clk;
   gaussian_blur_stream_if #(.PIX_W(PW), .IMG_W(W), .ADDR_W(AW)) bus();
   gaussian_blur_stream #(.PIX_W(PW), .IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .busy(busy), .done(done), .bus(bus.master));
   int img [H][W];
   int n_pass = 0, n_tot = 0, cyc = 0, wr_cnt = 0, done_cnt = 0, done_t = -1, t0 = 0, dc0 = 0;
   logic [W*PW-1:0] got [H];
   logic [AW-1:0]   exp_a [$];
   logic [W*PW-1:0] exp_d [$];
   initial bus.dst_stall = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      logic [W*PW-1:0] row;
      row = '0;
      if (bus.src_rd && bus.src_addr < AW'(H))
         for (int c = 0; c < W; c++) row[c*PW +: PW] = PW'(img[bus.src_addr][c]);
      bus.src_data <= row;
   end
   always @(negedge clk) begin
      logic [AW-1:0]   a;
      logic [W*PW-1:0] d;
      if (done) begin
         done_cnt++;
         done_t = cyc;
      end
      if (bus.dst_we) begin
         wr_cnt++;
         n_tot++;
         if (exp_a.size() == 0) $display("FAIL unexpected_write addr=%0d data=%h", bus.dst_addr, bus.dst_data);
         else begin
            a = exp_a.pop_front();
            d = exp_d.pop_front();
            if (bus.dst_addr !== a || bus.dst_data !== d)
               $display("FAIL write_row got addr=%0d data=%h, expected addr=%0d data=%h", bus.dst_addr, bus.dst_data, a, d);
            else n_pass++;
         end
         if (bus.dst_addr < AW'(H)) got[bus.dst_addr] = bus.dst_data;
      end
   end
   function automatic logic [PW-1:0] ref_px(input int m, input int r, input int c);
      int k [5];
      int rad, acc, sh, rr, cc;
      if (m != 0) k = '{1, 4, 6, 4, 1};
      else k = '{1, 2, 1, 0, 0};
      rad = m != 0 ? 2 : 1;
      sh  = m != 0 ? 8 : 4;
      acc = 0;
      for (int i = 0; i <= 2*rad; i++)
         for (int j = 0; j <= 2*rad; j++) begin
            rr = r + i - rad;
            cc = c + j - rad;
            if (rr >= 0 && rr < H && cc >= 0 && cc < W) acc += k[i]*k[j]*img[rr][cc];
         end
      return PW'((acc + (1 << (sh-1))) >> sh);
   endfunction
   function automatic logic [PW-1:0] px(input int r, input int c);
      logic [W*PW-1:0] row;
      row = got[r];
      return row[c*PW +: PW];
   endfunction
   task automatic set_const(input int v);
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
   endtask
   task automatic launch(input logic m);
      logic [W*PW-1:0] row;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) row[c*PW +: PW] = ref_px(int'(m), r, c);
         exp_a.push_back(AW'(r));
         exp_d.push_back(row);
         got[r] = 'x;
      end
      wr_cnt = 0;
      done_t = -1;
      dc0    = done_cnt;
      @(negedge clk);
      mode  = m;
      start = 1;
      t0    = cyc;
      @(negedge clk);
      start = 0;
   endtask
   task automatic wait_done;
      for (int i = 0; i < 200 && done_cnt == dc0; i++) @(posedge clk);
      repeat (3) @(posedge clk);
   endtask
   task automatic test_reset;
      rst = 1;
      repeat (2) @(negedge clk);
      n_tot++;
      if ({busy, done, bus.src_rd, bus.dst_we} !== 4'b0) $display("FAIL reset_strobes got %b want 0000", {busy, done, bus.src_rd, bus.dst_we});
      else n_pass++;
      n_tot++;
      if (bus.src_addr !== '0 || bus.dst_addr !== '0) $display("FAIL reset_addr got src=%0d dst=%0d want 0", bus.src_addr, bus.dst_addr);
      else n_pass++;
      n_tot++;
      if (bus.dst_data !== '0) $display("FAIL reset_data got %h want 0", bus.dst_data);
      else n_pass++;
      rst = 0;
      repeat (2) @(negedge clk);
      n_tot++;
      if (busy !== 1'b0 || bus.src_rd !== 1'b0) $display("FAIL idle_after_reset got busy=%b src_rd=%b want 0", busy, bus.src_rd);
      else n_pass++;
   endtask
   task automatic test_const3;
      set_const(100);
      launch(0);
      n_tot++;
      if (busy !== 1'b1 || bus.src_rd !== 1'b1 || bus.src_addr !== '0) $display("FAIL c3_first_read got busy=%b src_rd=%b addr=%0d want 1 1 0", busy, bus.src_rd, bus.src_addr);
      else n_pass++;
      wait_done;
      n_tot++;
      if (done_t - t0 !== 29) $display("FAIL c3_done_time got %0d want 29", done_t - t0);
      else n_pass++;
      n_tot++;
      if (wr_cnt !== 6) $display("FAIL c3_writes got %0d want 6", wr_cnt);
      else n_pass++;
      n_tot++;
      if (px(0, 0) !== 8'd56 || px(5, 7) !== 8'd56) $display("FAIL c3_corner got %0d %0d want 56", px(0, 0), px(5, 7));
      else n_pass++;
      n_tot++;
      if (px(0, 3) !== 8'd75 || px(5, 4) !== 8'd75 || px(2, 0) !== 8'd75) $display("FAIL c3_edge got %0d %0d %0d want 75", px(0, 3), px(5, 4), px(2, 0));
      else n_pass++;
      n_tot++;
      if (px(3, 3) !== 8'd100 || px(1, 6) !== 8'd100) $display("FAIL c3_interior got %0d %0d want 100", px(3, 3), px(1, 6));
      else n_pass++;
   endtask
   task automatic test_const5;
      set_const(100);
      launch(1);
      mode = 0;
      wait_done;
      n_tot++;
      if (done_t - t0 !== 33) $display("FAIL c5_done_time got %0d want 33", done_t - t0);
      else n_pass++;
      n_tot++;
      if (px(2, 2) !== 8'd100) $display("FAIL c5_interior got %0d want 100", px(2, 2));
      else n_pass++;
      n_tot++;
      if (px(0, 0) !== 8'd47 || px(5, 7) !== 8'd47) $display("FAIL c5_corner got %0d %0d want 47", px(0, 0), px(5, 7));
      else n_pass++;
      n_tot++;
      if (wr_cnt !== 6) $display("FAIL c5_writes got %0d want 6", wr_cnt);
      else n_pass++;
   endtask
   task automatic test_impulse;
      set_const(0);
      img[3][3] = 255;
      launch(0);
      wait_done;
      n_tot++;
      if (px(3, 3) !== 8'd64) $display("FAIL imp_centre got %0d want 64", px(3, 3));
      else n_pass++;
      n_tot++;
      if (px(2, 3) !== 8'd32 || px(3, 2) !== 8'd32 || px(4, 3) !== 8'd32 || px(3, 4) !== 8'd32) $display("FAIL imp_cross got %0d %0d %0d %0d want 32", px(2, 3), px(3, 2), px(4, 3), px(3, 4));
      else n_pass++;
      n_tot++;
      if (px(2, 2) !== 8'd16 || px(4, 4) !== 8'd16 || px(2, 4) !== 8'd16 || px(4, 2) !== 8'd16) $display("FAIL imp_diag got %0d %0d %0d %0d want 16", px(2, 2), px(4, 4), px(2, 4), px(4, 2));
      else n_pass++;
      n_tot++;
      if (px(0, 0) !== 8'd0 || px(3, 5) !== 8'd0 || px(1, 3) !== 8'd0) $display("FAIL imp_zero got %0d %0d %0d want 0", px(0, 0), px(3, 5), px(1, 3));
      else n_pass++;
   endtask
   task automatic test_stall;
      logic [W*PW-1:0] saved;
      set_const(100);
      img[2][1] = 7;
      img[1][5] = 200;
      launch(0);
      for (int i = 0; i < 100 && !(bus.dst_we === 1'b1 && bus.dst_addr === AW'(1)); i++) begin
         @(posedge clk);
         #2;
      end
      @(posedge clk);
      #1 bus.dst_stall = 1;
      repeat (2) @(posedge clk);
      saved = 'x;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #2;
         if (i == 0) saved = bus.dst_data;
         n_tot++;
         if (bus.dst_we !== 1'b0 || bus.dst_addr !== AW'(2) || bus.dst_data !== saved)
            $display("FAIL stall_hold cycle %0d got we=%b addr=%0d data=%h want 0 2 %h", i, bus.dst_we, bus.dst_addr, bus.dst_data, saved);
         else n_pass++;
      end
      @(posedge clk);
      #1 bus.dst_stall = 0;
      #1;
      n_tot++;
      if (bus.dst_we !== 1'b1 || bus.dst_addr !== AW'(2) || bus.dst_data !== saved)
         $display("FAIL stall_release got we=%b addr=%0d data=%h want 1 2 %h", bus.dst_we, bus.dst_addr, bus.dst_data, saved);
      else n_pass++;
      wait_done;
      n_tot++;
      if (done_t - t0 !== 34) $display("FAIL stall_done_time got %0d want 34", done_t - t0);
      else n_pass++;
      n_tot++;
      if (wr_cnt !== 6) $display("FAIL stall_writes got %0d want 6", wr_cnt);
      else n_pass++;
   endtask
   task automatic test_rst_mid;
      set_const(100);
      img[0][0] = 255;
      launch(0);
      repeat (13) @(posedge clk);
      #3 rst = 1;
      #1;
      n_tot++;
      if ({busy, done, bus.src_rd, bus.dst_we} !== 4'b0) $display("FAIL rst_mid_strobes got %b want 0000", {busy, done, bus.src_rd, bus.dst_we});
      else n_pass++;
      n_tot++;
      if (bus.dst_data !== '0 || bus.dst_addr !== '0 || bus.src_addr !== '0) $display("FAIL rst_mid_regs got data=%h dst=%0d src=%0d want 0", bus.dst_data, bus.dst_addr, bus.src_addr);
      else n_pass++;
      @(negedge clk);
      rst = 0;
      exp_a.delete();
      exp_d.delete();
      set_const(50);
      img[5][7] = 255;
      launch(0);
      wait_done;
      n_tot++;
      if (done_t - t0 !== 29 || wr_cnt !== 6) $display("FAIL rst_mid_rerun got done=%0d writes=%0d want 29 6", done_t - t0, wr_cnt);
      else n_pass++;
   endtask
   task automatic test_start_busy;
      int dcs;
      set_const(100);
      dcs = done_cnt;
      launch(1);
      repeat (5) @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (9) @(negedge clk);
      start = 1;
      mode  = 0;
      @(negedge clk);
      start = 0;
      wait_done;
      repeat (10) @(posedge clk);
      n_tot++;
      if (wr_cnt !== 6) $display("FAIL busy_start_writes got %0d want 6", wr_cnt);
      else n_pass++;
      n_tot++;
      if (done_cnt - dcs !== 1) $display("FAIL busy_start_done_pulses got %0d want 1", done_cnt - dcs);
      else n_pass++;
      n_tot++;
      if (done_t - t0 !== 33 || busy !== 1'b0) $display("FAIL busy_start_done_time got %0d busy=%b want 33 0", done_t - t0, busy);
      else n_pass++;
      n_tot++;
      if (exp_a.size() !== 0) $display("FAIL scoreboard_drain got %0d left want 0", exp_a.size());
      else n_pass++;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog timeout at cycle %0d", cyc);
      $fatal(1);
   end
   initial begin
      test_reset;
      test_const3;
      test_const5;
      test_impulse;
      test_stall;
      test_rst_mid;
      test_start_busy;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
